// File: rtl/itch_pkg.sv
// itch_pkg
// Shared definitions for the MoldUDP64 / ITCH parser slice: message type
// codes, the minimum body length each decoded type needs, the parser FSM
// state encoding and small helpers to classify a type byte.
package itch_pkg;

  localparam logic [7:0] ITCH_ADD    = 8'h41;  // 'A'
  localparam logic [7:0] ITCH_CANCEL = 8'h58;  // 'X'
  localparam logic [7:0] ITCH_DELETE = 8'h44;  // 'D'

  localparam logic [15:0] LEN_ADD    = 16'd15;
  localparam logic [15:0] LEN_CANCEL = 16'd11;
  localparam logic [15:0] LEN_DELETE = 16'd9;

  typedef enum logic [2:0] {
    S_HDR,
    S_LEN_HI,
    S_LEN_LO,
    S_BODY,
    S_FLUSH
  } state_t;

  function automatic logic is_known(input logic [7:0] t);
    return (t == ITCH_ADD) || (t == ITCH_CANCEL) || (t == ITCH_DELETE);
  endfunction

  // Minimum body length for a decodable message; 0 for unknown types.
  function automatic logic [15:0] req_len(input logic [7:0] t);
    case (t)
      ITCH_ADD:    return LEN_ADD;
      ITCH_CANCEL: return LEN_CANCEL;
      ITCH_DELETE: return LEN_DELETE;
      default:     return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_field_capture.sv
// itch_field_capture
// Assembles the fixed-offset ITCH fields from the message body byte stream.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_en         body byte accepted this cycle
//   i_idx        index of the byte within the message body (0 = type)
//   i_byte       body byte
//   o_type, o_order_id, o_qty, o_price
//                field values including the byte accepted this cycle, so the
//                parent can load a complete record on the last body byte.
module itch_field_capture #(
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_byte,
  output logic [7:0]       o_type,
  output logic [63:0]      o_order_id,
  output logic [15:0]      o_qty,
  output logic [31:0]      o_price
);

  logic [7:0]  r_type,  w_type;
  logic [63:0] r_order_id, w_order_id;
  logic [15:0] r_qty,   w_qty;
  logic [31:0] r_price, w_price;

  // Body layout: [0] type, [1..8] order id, [9..10] qty, [11..14] price,
  // all big-endian. Bytes beyond index 14 are surplus and left untouched.
  always_comb begin
    w_type     = r_type;
    w_order_id = r_order_id;
    w_qty      = r_qty;
    w_price    = r_price;
    if (i_en) begin
      if (i_idx == IDX_W'(0)) w_type = i_byte;
      for (int k = 0; k < 8; k++)
        if (i_idx == IDX_W'(k + 1)) w_order_id[8*(7-k) +: 8] = i_byte;
      for (int k = 0; k < 2; k++)
        if (i_idx == IDX_W'(k + 9)) w_qty[8*(1-k) +: 8] = i_byte;
      for (int k = 0; k < 4; k++)
        if (i_idx == IDX_W'(k + 11)) w_price[8*(3-k) +: 8] = i_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= '0;
      r_order_id <= '0;
      r_qty      <= '0;
      r_price    <= '0;
    end else begin
      r_type     <= w_type;
      r_order_id <= w_order_id;
      r_qty      <= w_qty;
      r_price    <= w_price;
    end
  end

  assign o_type     = w_type;
  assign o_order_id = w_order_id;
  assign o_qty      = w_qty;
  assign o_price    = w_price;

endmodule

// File: rtl/moldudp_itch_parser.sv
// moldudp_itch_parser
// Skips the Eth/IP/UDP/MoldUDP64 header of each packet, walks the
// length-prefixed message blocks and emits one record per 'A'/'X'/'D'.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast  MAC receive byte stream
//   m_valid/m_ready                 one-deep record handshake
//   m_msg_type, m_order_id, m_quantity, m_price   decoded record
//   msg_count, drop_count           wrapping statistics counters
module moldudp_itch_parser
  import itch_pkg::*;
#(
  parameter int HEADER_LEN  = 62,
  parameter int MAX_MSG_LEN = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_msg_type,
  output logic [63:0]      m_order_id,
  output logic [15:0]      m_quantity,
  output logic [31:0]      m_price,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int MAX_CNT = (HEADER_LEN > MAX_MSG_LEN) ? HEADER_LEN : MAX_MSG_LEN;
  localparam int IDX_W   = $clog2(MAX_CNT + 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_len_hi;
  logic [15:0]      r_len;
  logic [15:0]      w_len_full;
  logic             w_acc, w_cap_en, w_last_body, w_known;
  logic             w_emit, w_drop;
  logic [15:0]      w_req;
  logic [7:0]       w_cur_type;
  logic [63:0]      w_cur_id;
  logic [15:0]      w_cur_qty;
  logic [31:0]      w_cur_price;

  logic             r_m_valid;
  logic [7:0]       r_m_type;
  logic [63:0]      r_m_id;
  logic [15:0]      r_m_qty;
  logic [31:0]      r_m_price;
  logic [CNT_W-1:0] r_msg_count, r_drop_count;

  assign s_axis_tready = !r_m_valid || m_ready;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_cap_en      = w_acc && (r_state == S_BODY);
  assign w_len_full    = {r_len_hi, s_axis_tdata};
  assign w_last_body   = (16'(r_cnt) == (r_len - 16'd1));
  assign w_known       = is_known(w_cur_type);
  assign w_req         = req_len(w_cur_type);

  itch_field_capture #(.IDX_W(IDX_W)) u_capture (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_cap_en),
    .i_idx      (r_cnt),
    .i_byte     (s_axis_tdata),
    .o_type     (w_cur_type),
    .o_order_id (w_cur_id),
    .o_qty      (w_cur_qty),
    .o_price    (w_cur_price)
  );

  // Next-state logic. A tlast anywhere other than the end of a message (or
  // the low length byte of an empty block) is a truncation; only known
  // message types count it as a drop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_drop      = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_HDR: begin
          if (s_axis_tlast) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == IDX_W'(HEADER_LEN - 1)) begin
            w_state_nxt = S_LEN_HI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
        S_LEN_HI: w_state_nxt = s_axis_tlast ? S_HDR : S_LEN_LO;
        S_LEN_LO: begin
          w_cnt_nxt = '0;
          if (w_len_full == 16'd0) begin
            w_state_nxt = s_axis_tlast ? S_HDR : S_LEN_HI;
          end else if (s_axis_tlast) begin
            w_drop      = 1'b1;
            w_state_nxt = S_HDR;
          end else if (w_len_full > 16'(MAX_MSG_LEN)) begin
            w_drop      = 1'b1;
            w_state_nxt = S_FLUSH;
          end else begin
            w_state_nxt = S_BODY;
          end
        end
        S_BODY: begin
          if (w_last_body) begin
            if (w_known) begin
              if (r_len >= w_req) w_emit = 1'b1;
              else                w_drop = 1'b1;
            end
            w_state_nxt = s_axis_tlast ? S_HDR : S_LEN_HI;
            w_cnt_nxt   = '0;
          end else if (s_axis_tlast) begin
            w_drop      = w_known;
            w_state_nxt = S_HDR;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
        S_FLUSH: begin
          if (s_axis_tlast) begin
            w_state_nxt = S_HDR;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_HDR;
      r_cnt    <= '0;
      r_len_hi <= '0;
      r_len    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc && r_state == S_LEN_HI) r_len_hi <= s_axis_tdata;
      if (w_acc && r_state == S_LEN_LO) r_len    <= w_len_full;
    end
  end

  // Output register: fields not carried by a type are forced to zero so
  // surplus body bytes never leak into qty/price.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid    <= 1'b0;
      r_m_type     <= '0;
      r_m_id       <= '0;
      r_m_qty      <= '0;
      r_m_price    <= '0;
      r_msg_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_emit) begin
        r_m_valid <= 1'b1;
        r_m_type  <= w_cur_type;
        r_m_id    <= w_cur_id;
        r_m_qty   <= (w_cur_type == ITCH_DELETE) ? 16'd0 : w_cur_qty;
        r_m_price <= (w_cur_type == ITCH_ADD) ? w_cur_price : 32'd0;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_emit) r_msg_count  <= r_msg_count + CNT_W'(1);
      if (w_drop) r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  assign m_valid    = r_m_valid;
  assign m_msg_type = r_m_type;
  assign m_order_id = r_m_id;
  assign m_quantity = r_m_qty;
  assign m_price    = r_m_price;
  assign msg_count  = r_msg_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_moldudp_itch_parser.sv
// tb_moldudp_itch_parser
// Builds MoldUDP64/ITCH packets as byte queues, drives them through the
// parser and checks the emitted records against a scoreboard queue filled
// by a small reference model while the packets are built.
module tb_moldudp_itch_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        m_valid;
  logic        tbReady = 1'b1;
  logic [7:0]  m_msg_type;
  logic [63:0] m_order_id;
  logic [15:0] m_quantity;
  logic [31:0] m_price;
  logic [15:0] msg_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  moldudp_itch_parser #(
    .HEADER_LEN  (62),
    .MAX_MSG_LEN (64),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_valid       (m_valid),
    .m_ready       (tbReady),
    .m_msg_type    (m_msg_type),
    .m_order_id    (m_order_id),
    .m_quantity    (m_quantity),
    .m_price       (m_price),
    .msg_count     (msg_count),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [7:0]  typ;
    logic [15:0] len;
    logic [63:0] id;
    logic [15:0] qty;
    logic [31:0] price;
  } msgRec;

  logic [127:0] expQ[$];
  logic [7:0]   txData[$];
  logic         txLast[$];
  int           total = 0;
  int           bad = 0;
  int           expMsg = 0;
  int           expDrop = 0;
  int           stallCycles = 0;
  logic         monStalled = 1'b0;
  logic [127:0] heldRec = '0;
  logic [127:0] curRec;
  msgRec        vec[7];
  msgRec        mA, mX, mD, mZ, mD2;

  // Single comparison point: every check bumps total and, on mismatch, bad.
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] reqLen(input logic [7:0] t);
    if (t == 8'h41) return 16'd15;
    if (t == 8'h58) return 16'd11;
    if (t == 8'h44) return 16'd9;
    return 16'd0;
  endfunction

  // Wire image of body byte i: type, order id, qty, price, then filler.
  function automatic logic [7:0] bodyByte(input msgRec m, input int i);
    logic [63:0] t;
    if (i == 0) return m.typ;
    if (i <= 8)  begin t = m.id >> (8*(8-i));            return t[7:0]; end
    if (i <= 10) begin t = 64'(m.qty) >> (8*(10-i));     return t[7:0]; end
    if (i <= 14) begin t = 64'(m.price) >> (8*(14-i));   return t[7:0]; end
    return 8'hEE;
  endfunction

  task automatic pushByte(input logic [7:0] b, input logic last);
    txData.push_back(b);
    txLast.push_back(last);
  endtask

  task automatic addHeader();
    repeat (62) pushByte(8'hFF, 1'b0);
  endtask

  task automatic markLast();
    txLast[txLast.size()-1] = 1'b1;
  endtask

  // Appends one length-prefixed block and records what the parser must do
  // with it: emit a record, count a drop, or stay silent.
  task automatic addMsg(input msgRec m);
    logic [15:0] q;
    logic [31:0] p;
    pushByte(m.len[15:8], 1'b0);
    pushByte(m.len[7:0], 1'b0);
    for (int i = 0; i < int'(m.len); i++) pushByte(bodyByte(m, i), 1'b0);
    if (m.len != 16'd0 && reqLen(m.typ) != 16'd0) begin
      if (m.len >= reqLen(m.typ)) begin
        q = (m.typ == 8'h44) ? 16'd0 : m.qty;
        p = (m.typ == 8'h41) ? m.price : 32'd0;
        expQ.push_back({8'h00, m.typ, m.id, q, p});
        expMsg++;
      end else begin
        expDrop++;
      end
    end
  endtask

  // Drives the byte queue one byte per cycle, honouring tready; a byte
  // stuck for too long is reported and the rest of the queue abandoned.
  task automatic applyStimulus();
    int waitCyc;
    waitCyc = 0;
    while (txData.size() > 0) begin
      @(negedge clk);
      s_axis_tdata  = txData[0];
      s_axis_tlast  = txLast[0];
      s_axis_tvalid = 1'b1;
      #4;
      if (s_axis_tready) begin
        void'(txData.pop_front());
        void'(txLast.pop_front());
        waitCyc = 0;
      end else begin
        waitCyc++;
        if (waitCyc > 500) begin
          total++;
          bad++;
          $display("[TB] FAIL tready_timeout: got stalled expected accept");
          txData.delete();
          txLast.delete();
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic doReset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    tbReady       = 1'b1;
    expQ.delete();
    txData.delete();
    txLast.delete();
    expMsg  = 0;
    expDrop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for all expected records to drain, then checks counters.
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || m_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= 300) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_drain: got %0d pending expected 0", name, expQ.size());
    end
    checkOutput({name, "_msg_count"}, 128'(msg_count), 128'(expMsg));
    checkOutput({name, "_drop_count"}, 128'(drop_count), 128'(expDrop));
  endtask

  // Monitor: records are consumed on a handshake and compared in order;
  // while stalled the record must hold and tready must be low.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && m_valid) begin
        curRec = {8'h00, m_msg_type, m_order_id, m_quantity, m_price};
        if (tbReady) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_record: got %h expected none", curRec);
          end else begin
            checkOutput("record", curRec, expQ.pop_front());
          end
          monStalled = 1'b0;
        end else begin
          stallCycles++;
          checkOutput("tready_in_stall", 128'(s_axis_tready), 128'h0);
          if (monStalled) checkOutput("stall_stable", curRec, heldRec);
          heldRec    = curRec;
          monStalled = 1'b1;
        end
      end else begin
        monStalled = 1'b0;
      end
    end
  end

  initial begin
    mA  = '{8'h41, 16'd15, 64'h0102030405060708, 16'h0064, 32'h00002710};
    mX  = '{8'h58, 16'd11, 64'h1112131415161718, 16'h0032, 32'hDEADBEEF};
    mD  = '{8'h44, 16'd9,  64'h2122232425262728, 16'h7777, 32'hCAFEF00D};
    mZ  = '{8'h5A, 16'd5,  64'h3132333435363738, 16'h0001, 32'h00000002};
    mD2 = '{8'h44, 16'd9,  64'hA1A2A3A4A5A6A7A8, 16'h0000, 32'h00000000};

    vec[0] = '{8'h41, 16'd15, 64'h1111111111111111, 16'd7,     32'h12345678};
    vec[1] = '{8'h00, 16'd0,  64'h0,                16'd0,     32'h0};
    vec[2] = '{8'h44, 16'd5,  64'h2222222222222222, 16'd0,     32'h0};
    vec[3] = '{8'h58, 16'd20, 64'h3333333333333333, 16'hBEEF,  32'h55667788};
    vec[4] = '{8'h41, 16'd18, 64'h4444444444444444, 16'hFFFF,  32'hFFFFFFFF};
    vec[5] = '{8'h51, 16'd3,  64'h5555555555555555, 16'd1,     32'h1};
    vec[6] = '{8'h44, 16'd9,  64'hFFFFFFFFFFFFFFFF, 16'd9,     32'h9};

    // Reset state.
    doReset();
    checkOutput("reset_m_valid", 128'(m_valid), 128'h0);
    checkOutput("reset_tready", 128'(s_axis_tready), 128'h1);
    checkOutput("reset_record", {8'h00, m_msg_type, m_order_id, m_quantity, m_price}, 128'h0);
    checkOutput("reset_counters", {96'h0, msg_count, drop_count}, 128'h0);

    // Single 'A' message.
    addHeader(); addMsg(mA); markLast();
    applyStimulus();
    waitIdle("single_add");

    // 'A', 'X', 'D' back to back, consumer always ready.
    doReset();
    addHeader(); addMsg(mA); addMsg(mX); addMsg(mD); markLast();
    applyStimulus();
    waitIdle("three_msgs");

    // Same packet with the consumer stalling 10 cycles on the first record.
    doReset();
    stallCycles = 0;
    addHeader(); addMsg(mA); addMsg(mX); addMsg(mD); markLast();
    fork
      applyStimulus();
      begin : stallCtl
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_valid && n < 2000);
        tbReady = 1'b0;
        repeat (10) @(negedge clk);
        tbReady = 1'b1;
      end
    join
    waitIdle("backpressure");
    checkOutput("stall_cycles", 128'(stallCycles), 128'd10);

    // Unknown type skipped silently, followed by a 'D'.
    doReset();
    addHeader(); addMsg(mZ); addMsg(mD2); markLast();
    applyStimulus();
    waitIdle("unknown_type");

    // Truncated 'A' (tlast after 7 body bytes), then a fresh valid packet.
    doReset();
    addHeader();
    pushByte(8'h00, 1'b0); pushByte(8'h0F, 1'b0);
    for (int i = 0; i < 7; i++) pushByte(bodyByte(mA, i), 1'b0);
    markLast();
    expDrop++;
    addHeader(); addMsg(mA); markLast();
    applyStimulus();
    waitIdle("truncation");

    // Oversized length: the rest of the packet, even a valid-looking 'D',
    // must be flushed; the following packet decodes normally.
    doReset();
    addHeader();
    pushByte(8'h01, 1'b0); pushByte(8'h00, 1'b0);
    pushByte(8'h00, 1'b0); pushByte(8'h09, 1'b0);
    for (int i = 0; i < 9; i++) pushByte(bodyByte(mD, i), 1'b0);
    pushByte(8'h12, 1'b0); pushByte(8'h34, 1'b1);
    expDrop++;
    addHeader(); addMsg(mD); markLast();
    applyStimulus();
    waitIdle("oversize");

    // Table of mixed blocks: empty block, short known type, surplus bytes,
    // unknown type, all-ones fields.
    doReset();
    addHeader();
    for (int i = 0; i < 7; i++) addMsg(vec[i]);
    markLast();
    applyStimulus();
    waitIdle("table");

    // Asynchronous reset in the middle of an 'A' body.
    doReset();
    addHeader(); addMsg(mA);
    pushByte(8'h00, 1'b0); pushByte(8'h0F, 1'b0);
    for (int i = 0; i < 5; i++) pushByte(bodyByte(mA, i), 1'b0);
    applyStimulus();
    waitIdle("pre_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_record", {8'h00, m_msg_type, m_order_id, m_quantity, m_price}, 128'h0);
    checkOutput("async_reset_valid_tready", {126'h0, m_valid, s_axis_tready}, 128'h1);
    checkOutput("async_reset_counters", {96'h0, msg_count, drop_count}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expMsg  = 0;
    expDrop = 0;
    addHeader(); addMsg(mX); markLast();
    applyStimulus();
    waitIdle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
